cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
Multi-cycle control sequencer for the 8-bit accumulator CPU datapath with 16-bit addresses. It fetches each opcode and, for memory and jump instructions, the two address bytes. It then drives every datapath enable and mux select to execute the instruction. Inputs are the datapath's opcode and ACisZero; outputs connect one-to-one to the datapath control inputs.

Parameters:
ALU_WAIT, 0, extra EXEC cycles held before the AC write on ALU ops (0..7), to cover ALU result latency.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  8  instruction register contents from datapath
ACisZero  in  1  zero flag from datapath
writeEnableAC  out  1  AC load
writeEnableR  out  1  R load (R<=AC)
writeEnableMem  out  1  memory write (mem[addr]<=AC)
PCEnable  out  1  PC load
instructionRegisterEnable  out  1  IR load from memory
MSBaddressEnable  out  1  address-high register load
LSBaddressEnable  out  1  address-low register load
zeroEnable  out  1  zero-flag register load
muxSelectPC  out  1  0=PC+1, 1=fullAddress
muxSelectAddress  out  1  0=PC, 1=fullAddress
muxSelectALUtoAC  out  1  0=ALU result, 1=MEM/R path
muxSelectMEM_or_R_toAC  out  1  0=R, 1=memory
halted  out  1  high in HALT state
instrDone  out  1  one-cycle pulse on the final cycle of each instruction

Behaviour:
- One clock domain. Reset is synchronous and active-high. While reset is high, all outputs are 0, state<=FETCH and the wait counter<=0.
- All outputs are combinational from state, opcode and ACisZero. Any select not listed for a state is 0. Any enable not listed for a state is 0.
- Memory read is combinational from the address; the memory write and all register loads happen at the clock edge.
- Opcode map. Any other value executes as NOP.
  - 00 NOP
  - 01 LDAC Γ
  - 02 STAC Γ
  - 03 MVAC
  - 04 MOVR
  - 05 JUMP Γ
  - 06 JMPZ Γ
  - 07 JPNZ Γ
  - 08-0F ALU ops; the datapath takes the ALU select from opcode[2:0]
  - FF HALT
  - Γ means the opcode is followed by two address bytes: MSB first, then LSB.
- FETCH: instructionRegisterEnable=1, PCEnable=1, muxSelectAddress=0, muxSelectPC=0. Next state is DECODE.
- DECODE: no enables asserted.
  - opcode 01/02/05/06/07 -> ADDR_HI
  - opcode FF -> HALT
  - otherwise -> EXEC
- ADDR_HI: MSBaddressEnable=1, PCEnable=1, muxSelectAddress=0, muxSelectPC=0. Next state is ADDR_LO.
- ADDR_LO: LSBaddressEnable=1, PCEnable=1, muxSelectAddress=0, muxSelectPC=0. Next state is EXEC.
- EXEC, per opcode:
  - LDAC: muxSelectAddress=1, muxSelectALUtoAC=1, muxSelectMEM_or_R_toAC=1, writeEnableAC=1, zeroEnable=1.
  - STAC: muxSelectAddress=1, writeEnableMem=1.
  - MVAC: writeEnableR=1.
  - MOVR: muxSelectALUtoAC=1, muxSelectMEM_or_R_toAC=0, writeEnableAC=1, zeroEnable=1.
  - JUMP: muxSelectPC=1, PCEnable=1.
  - JMPZ: muxSelectPC=1, PCEnable=ACisZero.
  - JPNZ: muxSelectPC=1, PCEnable=~ACisZero.
  - ALU ops (08-0F): muxSelectALUtoAC=0 throughout. The 3-bit wait counter counts 0..ALU_WAIT. writeEnableAC and zeroEnable are asserted only when counter==ALU_WAIT; the counter clears on leaving EXEC.
  - NOP/unknown: nothing asserted.
  - EXEC goes to FETCH after its final cycle. instrDone=1 on that cycle.
- HALT: all enables 0, halted=1. The FSM stays in HALT until reset. instrDone pulses once on the DECODE->HALT cycle.
- Instruction lengths at ALU_WAIT=0:
  - 1-byte instructions: 3 cycles.
  - Γ instructions: 5 cycles.
  - ALU ops: 3+ALU_WAIT cycles.
- Conditional jumps sample ACisZero in EXEC. When not taken, PC already points past the address bytes.
- Reset asserted mid-instruction aborts it: no partial write occurs after the reset edge, and execution restarts at FETCH. The datapath PC resets to 0x0000.
- The datapath's zero register sets on reset, so ACisZero=1 after reset until the first AC write.
- At most one of writeEnableAC, writeEnableMem, writeEnableR is high in any cycle.
- PCEnable and muxSelectPC=1 together occur only in EXEC.

Test Plan:
1. Program 01 00 10 at 0x0000, mem[0x0010]=0x5A -> after 5 cycles AC=0x5A and ACisZero=0. instrDone is high in cycle 5. PC=0x0003.
2. LDAC 0x0010 (=0x07), 03 (MVAC), 08 (ADD), 02 00 20 (STAC) -> mem[0x0020]=0x0E. The MVAC cycle asserts only writeEnableR. writeEnableMem is high for exactly one cycle.
3. AC=0x00 then 06 00 40 (JMPZ) -> PC=0x0040. With AC=0x01 the same JMPZ is not taken and PC=0x0006 (instruction at 0x0003). Repeat with 07 and check the opposite outcomes.
4. ALU_WAIT=2, opcode 0A (INAC) with AC=0xFF -> writeEnableAC is asserted only on the 3rd EXEC cycle. AC=0x00, ACisZero=1, total 5 cycles.
5. Opcode FF -> halted=1 from the cycle after DECODE. There is no PCEnable for 20 cycles. Reset then gives halted=0 and a fetch from 0x0000.
6. Reset asserted during ADDR_LO of a STAC -> all outputs are 0 during reset. There is no memory write, and the next cycle after reset deasserts is FETCH. Opcode 0x3C behaves as NOP (3 cycles, no writes).

Source files
------------

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle control sequencer for the 8-bit accumulator CPU
module cpu_control_fsm #(
    parameter int ALU_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic       ACisZero,
    output logic       writeEnableAC,
    output logic       writeEnableR,
    output logic       writeEnableMem,
    output logic       PCEnable,
    output logic       instructionRegisterEnable,
    output logic       MSBaddressEnable,
    output logic       LSBaddressEnable,
    output logic       zeroEnable,
    output logic       muxSelectPC,
    output logic       muxSelectAddress,
    output logic       muxSelectALUtoAC,
    output logic       muxSelectMEM_or_R_toAC,
    output logic       halted,
    output logic       instrDone
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(ALU_WAIT);
    localparam logic [7:0] OP_LDAC   = 8'h01;
    localparam logic [7:0] OP_STAC   = 8'h02;
    localparam logic [7:0] OP_MVAC   = 8'h03;
    localparam logic [7:0] OP_MOVR   = 8'h04;
    localparam logic [7:0] OP_JUMP   = 8'h05;
    localparam logic [7:0] OP_JMPZ   = 8'h06;
    localparam logic [7:0] OP_JPNZ   = 8'h07;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       is_alu;
    logic       has_addr;

    assign is_alu   = (opcode[7:3] == 5'b00001);
    assign has_addr = (opcode == OP_LDAC) || (opcode == OP_STAC) || (opcode == OP_JUMP)
                   || (opcode == OP_JMPZ) || (opcode == OP_JPNZ);

    // Outputs stay at 0 for the whole reset cycle so nothing is written mid-abort.
    always_comb begin
        writeEnableAC             = 1'b0;
        writeEnableR              = 1'b0;
        writeEnableMem            = 1'b0;
        PCEnable                  = 1'b0;
        instructionRegisterEnable = 1'b0;
        MSBaddressEnable          = 1'b0;
        LSBaddressEnable          = 1'b0;
        zeroEnable                = 1'b0;
        muxSelectPC               = 1'b0;
        muxSelectAddress          = 1'b0;
        muxSelectALUtoAC          = 1'b0;
        muxSelectMEM_or_R_toAC    = 1'b0;
        halted                    = 1'b0;
        instrDone                 = 1'b0;
        state_d                   = state_q;
        wait_d                    = wait_q;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    instructionRegisterEnable = 1'b1;
                    PCEnable                  = 1'b1;
                    state_d                   = S_DECODE;
                end
                S_DECODE: begin
                    if (has_addr) begin
                        state_d = S_ADDR_HI;
                    end else if (opcode == OP_HALT) begin
                        state_d   = S_HALT;
                        instrDone = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_ADDR_HI: begin
                    MSBaddressEnable = 1'b1;
                    PCEnable         = 1'b1;
                    state_d          = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    LSBaddressEnable = 1'b1;
                    PCEnable         = 1'b1;
                    state_d          = S_EXEC;
                end
                S_EXEC: begin
                    state_d   = S_FETCH;
                    wait_d    = '0;
                    instrDone = 1'b1;
                    case (opcode)
                        OP_LDAC: begin
                            muxSelectAddress       = 1'b1;
                            muxSelectALUtoAC       = 1'b1;
                            muxSelectMEM_or_R_toAC = 1'b1;
                            writeEnableAC          = 1'b1;
                            zeroEnable             = 1'b1;
                        end
                        OP_STAC: begin
                            muxSelectAddress = 1'b1;
                            writeEnableMem   = 1'b1;
                        end
                        OP_MVAC: writeEnableR = 1'b1;
                        OP_MOVR: begin
                            muxSelectALUtoAC = 1'b1;
                            writeEnableAC    = 1'b1;
                            zeroEnable       = 1'b1;
                        end
                        OP_JUMP: begin
                            muxSelectPC = 1'b1;
                            PCEnable    = 1'b1;
                        end
                        OP_JMPZ: begin
                            muxSelectPC = 1'b1;
                            PCEnable    = ACisZero;
                        end
                        OP_JPNZ: begin
                            muxSelectPC = 1'b1;
                            PCEnable    = ~ACisZero;
                        end
                        default: begin
                            // ALU ops hold EXEC until the result has had ALU_WAIT extra cycles.
                            if (is_alu && (wait_q != WAIT_LAST)) begin
                                state_d   = S_EXEC;
                                wait_d    = wait_q + 3'd1;
                                instrDone = 1'b0;
                            end else if (is_alu) begin
                                writeEnableAC = 1'b1;
                                zeroEnable    = 1'b1;
                            end
                        end
                    endcase
                end
                S_HALT: halted = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - randomized bench for cpu_control_fsm with datapath and ISA model
module tb_cpu_control_fsm;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dp_ir, dp_ac, dp_r, dp_ah, dp_al;
    logic [15:0] dp_pc;
    logic        dp_z;
    logic        writeEnableAC, writeEnableR, writeEnableMem, PCEnable;
    logic        instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable, zeroEnable;
    logic        muxSelectPC, muxSelectAddress, muxSelectALUtoAC, muxSelectMEM_or_R_toAC;
    logic        halted, instrDone;
    logic [15:0] ctl;
    logic [7:0]  mem [0:65535];

    int          n_checks = 0;
    int          n_err = 0;
    int          last_len;
    logic [15:0] m_pc;
    logic [7:0]  m_ac, m_r;
    logic        m_z;

    assign ctl = {writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
                  instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable, zeroEnable,
                  muxSelectPC, muxSelectAddress, muxSelectALUtoAC, muxSelectMEM_or_R_toAC,
                  halted, instrDone, 2'b00};

    cpu_control_fsm #(.ALU_WAIT(W)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .opcode                    (dp_ir),
        .ACisZero                  (dp_z),
        .writeEnableAC             (writeEnableAC),
        .writeEnableR              (writeEnableR),
        .writeEnableMem            (writeEnableMem),
        .PCEnable                  (PCEnable),
        .instructionRegisterEnable (instructionRegisterEnable),
        .MSBaddressEnable          (MSBaddressEnable),
        .LSBaddressEnable          (LSBaddressEnable),
        .zeroEnable                (zeroEnable),
        .muxSelectPC               (muxSelectPC),
        .muxSelectAddress          (muxSelectAddress),
        .muxSelectALUtoAC          (muxSelectALUtoAC),
        .muxSelectMEM_or_R_toAC    (muxSelectMEM_or_R_toAC),
        .halted                    (halted),
        .instrDone                 (instrDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] x,
                                         input logic [7:0] y);
        case (s)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x + 8'd1;
            3'd3: return 8'd0;
            3'd4: return x & y;
            3'd5: return x | y;
            3'd6: return x ^ y;
            default: return ~x;
        endcase
    endfunction

    // Datapath: controls captured before the edge, registers updated at the edge.
    task automatic step();
        logic [15:0] addr;
        logic [7:0]  rd, ain;
        logic        rst, ire, pce, selpc, msb, lsb, wm, wr, wac, ze;
        addr  = muxSelectAddress ? {dp_ah, dp_al} : dp_pc;
        rd    = mem[addr];
        ain   = muxSelectALUtoAC ? (muxSelectMEM_or_R_toAC ? rd : dp_r)
                                 : alu_f(dp_ir[2:0], dp_ac, dp_r);
        rst   = reset;
        ire   = instructionRegisterEnable;
        pce   = PCEnable;
        selpc = muxSelectPC;
        msb   = MSBaddressEnable;
        lsb   = LSBaddressEnable;
        wm    = writeEnableMem;
        wr    = writeEnableR;
        wac   = writeEnableAC;
        ze    = zeroEnable;
        @(posedge clk);
        if (rst) begin
            dp_pc <= '0; dp_ac <= '0; dp_r <= '0; dp_z <= 1'b1;
            dp_ir <= '0; dp_ah <= '0; dp_al <= '0;
        end else begin
            if (ire) dp_ir <= rd;
            if (pce) dp_pc <= selpc ? {dp_ah, dp_al} : dp_pc + 16'd1;
            if (msb) dp_ah <= rd;
            if (lsb) dp_al <= rd;
            if (wm)  mem[addr] = dp_ac;
            if (wr)  dp_r <= dp_ac;
            if (wac) dp_ac <= ain;
            if (ze)  dp_z <= (ain == 8'd0);
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        chk("rst_ctl", 32'(ctl), 32'd0);
        repeat (cycles) begin
            step();
            chk("rst_ctl", 32'(ctl), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("fetch_ire", 32'(instructionRegisterEnable), 32'd1);
        chk("fetch_pce", 32'(PCEnable), 32'd1);
        chk("fetch_sel", 32'({muxSelectAddress, muxSelectPC}), 32'd0);
        m_pc = '0; m_ac = '0; m_r = '0; m_z = 1'b1;
    endtask

    // Places one instruction at the model PC, runs it and compares against the ISA rules.
    task automatic run_instr(input logic [7:0] op, input logic [15:0] a);
        logic [15:0] pc0, p1, p2, nxt;
        logic        gamma, alu, hlt, taken, e_wac, e_wr, e_wm;
        int          e_len, e_pce, n, c_wac, c_wr, c_wm, c_pce, c_jmp, l_wac, l_jmp, multi;
        bit          done;
        pc0 = m_pc; p1 = pc0 + 16'd1; p2 = pc0 + 16'd2;
        mem[pc0] = op; mem[p1] = a[15:8]; mem[p2] = a[7:0];
        gamma = (op == 8'h01) || (op == 8'h02) || (op == 8'h05) || (op == 8'h06) || (op == 8'h07);
        alu   = (op >= 8'h08) && (op <= 8'h0F);
        hlt   = (op == 8'hFF);
        taken = (op == 8'h05) || (op == 8'h06 && m_z) || (op == 8'h07 && !m_z);
        e_len = hlt ? 2 : gamma ? 5 : alu ? 3 + W : 3;
        e_wac = (op == 8'h01) || (op == 8'h04) || alu;
        e_wr  = (op == 8'h03);
        e_wm  = (op == 8'h02);
        e_pce = 1 + (gamma ? 2 : 0) + (taken ? 1 : 0);
        nxt   = gamma ? pc0 + 16'd3 : p1;
        if (taken) nxt = a;
        n = 0; c_wac = 0; c_wr = 0; c_wm = 0; c_pce = 0; c_jmp = 0;
        l_wac = 0; l_jmp = 0; multi = 0; done = 0;
        while (!done && n < 40) begin
            n++;
            if (writeEnableAC) begin c_wac++; l_wac = n; end
            if (writeEnableR) c_wr++;
            if (writeEnableMem) c_wm++;
            if (PCEnable) c_pce++;
            if (PCEnable && muxSelectPC) begin c_jmp++; l_jmp = n; end
            if (int'(writeEnableAC) + int'(writeEnableR) + int'(writeEnableMem) > 1) multi++;
            if (instrDone) done = 1;
            step();
        end
        last_len = n;
        if (op == 8'h01) m_ac = mem[a];
        else if (op == 8'h04) m_ac = m_r;
        else if (alu) m_ac = alu_f(op[2:0], m_ac, m_r);
        if (op == 8'h03) m_r = m_ac;
        if (e_wac) m_z = (m_ac == 8'd0);
        m_pc = nxt;
        chk("done", 32'(done), 32'd1);
        chk("len", 32'(n), 32'(e_len));
        chk("wac_cnt", 32'(c_wac), 32'(e_wac));
        chk("wac_last", 32'(l_wac), e_wac ? 32'(e_len) : 32'd0);
        chk("wr_cnt", 32'(c_wr), 32'(e_wr));
        chk("wm_cnt", 32'(c_wm), 32'(e_wm));
        chk("pce_cnt", 32'(c_pce), 32'(e_pce));
        chk("jmp_cnt", 32'(c_jmp), 32'(taken));
        chk("jmp_last", 32'(l_jmp), taken ? 32'(e_len) : 32'd0);
        chk("one_write", 32'(multi), 32'd0);
        chk("pc", 32'(dp_pc), 32'(m_pc));
        chk("ac", 32'(dp_ac), 32'(m_ac));
        chk("r", 32'(dp_r), 32'(m_r));
        chk("zero", 32'(dp_z), 32'(m_z));
        chk("ir", 32'(dp_ir), 32'(op));
        chk("halted", 32'(halted), 32'(hlt));
        if (e_wm) chk("stac_mem", 32'(mem[a]), 32'(m_ac));
    endtask

    int          c_pe, c_nh;
    logic [15:0] spc, sp1, sp2;
    logic [7:0]  saved, op;
    logic [15:0] a;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        do_reset(2);

        mem[16'h0010] = 8'h5A;
        run_instr(8'h01, 16'h0010);
        chk("t1_ac", 32'(dp_ac), 32'h5A);
        chk("t1_pc", 32'(dp_pc), 32'h0003);
        chk("t1_z", 32'(dp_z), 32'd0);
        chk("t1_len", 32'(last_len), 32'd5);

        mem[16'h0010] = 8'h07;
        run_instr(8'h01, 16'h0010);
        run_instr(8'h03, 16'h0000);
        run_instr(8'h08, 16'h0000);
        run_instr(8'h02, 16'h0020);
        chk("t2_mem", 32'(mem[16'h0020]), 32'h0E);

        mem[16'h0030] = 8'h00;
        mem[16'h0031] = 8'h01;
        do_reset(1); run_instr(8'h01, 16'h0030); run_instr(8'h06, 16'h0040);
        chk("jmpz_taken", 32'(dp_pc), 32'h0040);
        do_reset(1); run_instr(8'h01, 16'h0031); run_instr(8'h06, 16'h0040);
        chk("jmpz_not", 32'(dp_pc), 32'h0006);
        do_reset(1); run_instr(8'h01, 16'h0030); run_instr(8'h07, 16'h0040);
        chk("jpnz_not", 32'(dp_pc), 32'h0006);
        do_reset(1); run_instr(8'h01, 16'h0031); run_instr(8'h07, 16'h0040);
        chk("jpnz_taken", 32'(dp_pc), 32'h0040);

        mem[16'h0032] = 8'hFF;
        run_instr(8'h01, 16'h0032);
        run_instr(8'h0A, 16'h0000);
        chk("inac_ac", 32'(dp_ac), 32'h00);
        chk("inac_z", 32'(dp_z), 32'd1);
        chk("inac_len", 32'(last_len), 32'd5);

        spc = m_pc; sp1 = spc + 16'd1; sp2 = spc + 16'd2;
        mem[spc] = 8'h02; mem[sp1] = 8'h01; mem[sp2] = 8'h00;
        saved = ~m_ac;
        mem[16'h0100] = saved;
        step(); step(); step();
        chk("stac_addr_lo", 32'(LSBaddressEnable), 32'd1);
        do_reset(2);
        chk("stac_abort_mem", 32'(mem[16'h0100]), 32'(saved));
        run_instr(8'h3C, 16'h0100);
        chk("nop_len", 32'(last_len), 32'd3);

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 5))
                0:       op = 8'($urandom_range(0, 7));
                1, 2:    op = 8'h08 + 8'($urandom_range(0, 7));
                3:       op = 8'($urandom_range(1, 2));
                4:       op = 8'($urandom_range(5, 7));
                default: op = 8'($urandom_range(16, 254));
            endcase
            a = 16'($urandom);
            if (op == 8'h01) mem[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_instr(op, a);
        end

        run_instr(8'hFF, 16'h0000);
        c_pe = 0; c_nh = 0;
        repeat (20) begin
            if (PCEnable) c_pe++;
            if (!halted) c_nh++;
            step();
        end
        chk("halt_pce", 32'(c_pe), 32'd0);
        chk("halt_hold", 32'(c_nh), 32'd0);
        do_reset(1);
        chk("post_halt", 32'(halted), 32'd0);
        chk("post_halt_pc", 32'(dp_pc), 32'h0000);
        run_instr(8'h00, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
